// File: rtl/life_board_engine.sv
// Game-of-Life simulation core: WIDTH x HEIGHT board with a run-time birth/survive rule,
// row-wise host loading and N-generation runs that stop early once the board settles.
module life_board_engine #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int WRAP   = 1,
    parameter int GEN_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    input  logic                      wr_en,
    input  logic [$clog2(HEIGHT)-1:0] wr_row,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic [8:0]                birth_mask,
    input  logic [8:0]                survive_mask,
    input  logic [GEN_W-1:0]          step_count,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [WIDTH*HEIGHT-1:0]   board,
    output logic [GEN_W-1:0]          generation,
    output logic                      stable,
    output logic                      extinct
);

    localparam int CELLS = WIDTH * HEIGHT;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CELLS-1:0]   board_q, board_d;
    logic [CELLS-1:0]   next_board;
    logic [GEN_W-1:0]   gen_q, gen_d;
    logic [GEN_W-1:0]   remaining_q, remaining_d;
    logic [8:0]         birth_q, birth_d;
    logic [8:0]         survive_q, survive_d;
    logic               stable_q, stable_d;

    // Neighbour positions are resolved at elaboration; without WRAP, off-grid taps tie to 0.
    for (genvar r = 0; r < HEIGHT; r++) begin : g_row
        for (genvar c = 0; c < WIDTH; c++) begin : g_col
            localparam int RU    = (r + HEIGHT - 1) % HEIGHT;
            localparam int RD    = (r + 1) % HEIGHT;
            localparam int CL    = (c + WIDTH - 1) % WIDTH;
            localparam int CR    = (c + 1) % WIDTH;
            localparam bit HAS_U = (WRAP != 0) || (r > 0);
            localparam bit HAS_D = (WRAP != 0) || (r < HEIGHT - 1);
            localparam bit HAS_L = (WRAP != 0) || (c > 0);
            localparam bit HAS_R = (WRAP != 0) || (c < WIDTH - 1);

            logic [7:0] nb;
            logic [3:0] count;

            assign nb[0] = (HAS_U && HAS_L) ? board_q[RU*WIDTH + CL] : 1'b0;
            assign nb[1] = HAS_U            ? board_q[RU*WIDTH + c]  : 1'b0;
            assign nb[2] = (HAS_U && HAS_R) ? board_q[RU*WIDTH + CR] : 1'b0;
            assign nb[3] = HAS_L            ? board_q[r*WIDTH + CL]  : 1'b0;
            assign nb[4] = HAS_R            ? board_q[r*WIDTH + CR]  : 1'b0;
            assign nb[5] = (HAS_D && HAS_L) ? board_q[RD*WIDTH + CL] : 1'b0;
            assign nb[6] = HAS_D            ? board_q[RD*WIDTH + c]  : 1'b0;
            assign nb[7] = (HAS_D && HAS_R) ? board_q[RD*WIDTH + CR] : 1'b0;

            always_comb begin
                count = '0;
                for (int k = 0; k < 8; k++) begin
                    count = count + {3'b000, nb[k]};
                end
            end

            assign next_board[r*WIDTH + c] = board_q[r*WIDTH + c] ? survive_q[count]
                                                                  : birth_q[count];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            board_q     <= '0;
            gen_q       <= '0;
            remaining_q <= '0;
            birth_q     <= '0;
            survive_q   <= '0;
            stable_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            board_q     <= board_d;
            gen_q       <= gen_d;
            remaining_q <= remaining_d;
            birth_q     <= birth_d;
            survive_q   <= survive_d;
            stable_q    <= stable_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (step_count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (ena && ((next_board == board_q) || (remaining_q == GEN_W'(1)))) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A settled board ends the run without counting a generation.
    always_comb begin
        board_d     = board_q;
        gen_d       = gen_q;
        remaining_d = remaining_q;
        birth_d     = birth_q;
        survive_d   = survive_q;
        stable_d    = stable_q;
        case (state_q)
            IDLE: begin
                if (wr_en && (int'(wr_row) < HEIGHT)) begin
                    board_d[int'(wr_row)*WIDTH +: WIDTH] = wr_data;
                    stable_d = 1'b0;
                end
                if (start) begin
                    birth_d     = birth_mask;
                    survive_d   = survive_mask;
                    remaining_d = step_count;
                end
            end
            RUN: begin
                if (ena) begin
                    if (next_board == board_q) begin
                        stable_d = 1'b1;
                    end else begin
                        board_d     = next_board;
                        gen_d       = gen_q + GEN_W'(1);
                        stable_d    = 1'b0;
                        remaining_d = remaining_q - GEN_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    assign board      = board_q;
    assign generation = gen_q;
    assign stable     = stable_q;
    assign extinct    = (board_q == '0);

endmodule

// File: tb/tb_life_board_engine.sv
// Self-checking bench for life_board_engine: three instances (8x8 torus, 8x8 dead edges,
// 8x6 torus) checked against a behavioural Life model through a result scoreboard.
module tb_life_board_engine;

    localparam int NU = 3;
    localparam logic [8:0] CONWAY_B = 9'h008;
    localparam logic [8:0] CONWAY_S = 9'h00C;
    localparam logic [8:0] HIGHL_B  = 9'h048;
    localparam logic [63:0] GLIDER  = 64'h0000_0000_0007_0402;

    logic clk = 1'b0;
    logic rst_n;
    logic [NU-1:0]       ena, wr_en, start;
    logic [NU-1:0][2:0]  wr_row;
    logic [NU-1:0][7:0]  wr_data;
    logic [NU-1:0][8:0]  birth, survive;
    logic [NU-1:0][15:0] steps;
    wire  [NU-1:0]       busy, done, stable, extinct;
    wire  [NU-1:0][15:0] gen;
    wire  [63:0]         board0, board1;
    wire  [47:0]         board2;

    typedef struct {
        logic [63:0] board;
        logic [15:0] gen;
        logic        stable;
        int          lat;
        string       tag;
    } sb_entry_t;

    sb_entry_t   sb[$];
    logic [63:0] mboard[NU];
    logic [15:0] mgen[NU];
    logic        mstable[NU];
    int          tests = 0;
    int          failed = 0;

    always #5 clk = ~clk;

    life_board_engine #(.WIDTH(8), .HEIGHT(8), .WRAP(1), .GEN_W(16)) dut0 (
        .clk(clk), .rst(rst_n), .ena(ena[0]), .wr_en(wr_en[0]), .wr_row(wr_row[0]),
        .wr_data(wr_data[0]), .birth_mask(birth[0]), .survive_mask(survive[0]),
        .step_count(steps[0]), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .board(board0), .generation(gen[0]), .stable(stable[0]), .extinct(extinct[0])
    );

    life_board_engine #(.WIDTH(8), .HEIGHT(8), .WRAP(0), .GEN_W(16)) dut1 (
        .clk(clk), .rst(rst_n), .ena(ena[1]), .wr_en(wr_en[1]), .wr_row(wr_row[1]),
        .wr_data(wr_data[1]), .birth_mask(birth[1]), .survive_mask(survive[1]),
        .step_count(steps[1]), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .board(board1), .generation(gen[1]), .stable(stable[1]), .extinct(extinct[1])
    );

    life_board_engine #(.WIDTH(8), .HEIGHT(6), .WRAP(1), .GEN_W(16)) dut2 (
        .clk(clk), .rst(rst_n), .ena(ena[2]), .wr_en(wr_en[2]), .wr_row(wr_row[2]),
        .wr_data(wr_data[2]), .birth_mask(birth[2]), .survive_mask(survive[2]),
        .step_count(steps[2]), .start(start[2]), .busy(busy[2]), .done(done[2]),
        .board(board2), .generation(gen[2]), .stable(stable[2]), .extinct(extinct[2])
    );

    function automatic int unit_h(input int u);
        return (u == 2) ? 6 : 8;
    endfunction

    function automatic bit unit_wrap(input int u);
        return (u != 1);
    endfunction

    function automatic logic [63:0] unit_mask(input int u);
        return (u == 2) ? 64'h0000_FFFF_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] cur_board(input int u);
        case (u)
            0:       return board0;
            1:       return board1;
            default: return {16'h0000, board2};
        endcase
    endfunction

    // Reference generation step written directly from row/column coordinates.
    function automatic logic [63:0] life_next(input logic [63:0] b, input int w, input int h,
                                              input bit wrap, input logic [8:0] bm,
                                              input logic [8:0] sm);
        logic [63:0] nb = '0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                int n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr = r + dr;
                        int cc = c + dc;
                        if (dr == 0 && dc == 0) continue;
                        if (wrap) begin
                            rr = (rr + h) % h;
                            cc = (cc + w) % w;
                            n += int'(b[rr*w + cc]);
                        end else if (rr >= 0 && rr < h && cc >= 0 && cc < w) begin
                            n += int'(b[rr*w + cc]);
                        end
                    end
                end
                nb[r*w + c] = b[r*w + c] ? sm[n] : bm[n];
            end
        end
        return nb;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < NU; u++) begin
            mboard[u]  = '0;
            mgen[u]    = '0;
            mstable[u] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic load_board(input int u, input logic [63:0] b);
        for (int r = 0; r < unit_h(u); r++) begin
            @(negedge clk);
            wr_en[u]   = 1'b1;
            wr_row[u]  = 3'(r);
            wr_data[u] = b[r*8 +: 8];
        end
        @(negedge clk);
        wr_en[u]   = 1'b0;
        mboard[u]  = b & unit_mask(u);
        mstable[u] = 1'b0;
    endtask

    // Model the run, queue the expectation, then drive start and compare once done appears.
    task automatic applyStimulus(input int u, input int n, input logic [8:0] bm,
                                 input logic [8:0] sm, input int stall_at, input int stall_len,
                                 input bit inject, input string tag);
        sb_entry_t   e;
        logic [63:0] b, nxt;
        logic [63:0] hist[$];
        logic [15:0] g, g0;
        logic        st;
        int          lat, rem, cyc;
        bit          seen;

        b = mboard[u]; g = mgen[u]; g0 = g; st = mstable[u]; lat = 1;
        hist.push_back(b);
        if (n != 0) begin
            rem = n;
            for (int i = 0; i < 70000 && rem > 0; i++) begin
                nxt = life_next(b, 8, unit_h(u), unit_wrap(u), bm, sm);
                lat++;
                if (nxt == b) begin
                    st  = 1'b1;
                    rem = 0;
                end else begin
                    b = nxt; g = g + 16'd1; st = 1'b0; rem--;
                    hist.push_back(b);
                end
            end
            lat += stall_len;
        end
        e.board = b; e.gen = g; e.stable = st; e.lat = lat; e.tag = tag;
        sb.push_back(e);
        mboard[u] = b; mgen[u] = g; mstable[u] = st;

        @(negedge clk);
        birth[u] = bm; survive[u] = sm; steps[u] = 16'(n); start[u] = 1'b1;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < lat + 20) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                start[u] = 1'b0;
                if (n != 0) checkOutput({tag, "_busy"}, 64'(busy[u]), 64'd1);
            end
            if (done[u]) begin
                seen = 1'b1;
            end else begin
                if (inject && cyc == 1) begin
                    wr_en[u] = 1'b1; wr_row[u] = 3'd5; wr_data[u] = 8'hFF;
                    birth[u] = 9'h1FF; survive[u] = 9'h000;
                end
                if (inject && cyc == 2) wr_en[u] = 1'b0;
                if (stall_len > 0 && cyc == stall_at) ena[u] = 1'b0;
                if (stall_len > 0 && cyc > stall_at && cyc <= stall_at + stall_len) begin
                    checkOutput({tag, "_frozen_board"}, cur_board(u), hist[stall_at-1]);
                    checkOutput({tag, "_frozen_gen"}, 64'(gen[u]), 64'(g0 + 16'(stall_at - 1)));
                    if (cyc == stall_at + stall_len) ena[u] = 1'b1;
                end
            end
        end
        wr_en[u] = 1'b0;
        ena[u]   = 1'b1;

        e = sb.pop_front();
        checkOutput({e.tag, "_done_seen"}, 64'(seen), 64'd1);
        checkOutput({e.tag, "_latency"}, 64'(cyc), 64'(e.lat));
        checkOutput({e.tag, "_board"}, cur_board(u), e.board);
        checkOutput({e.tag, "_gen"}, 64'(gen[u]), 64'(e.gen));
        checkOutput({e.tag, "_stable"}, 64'(stable[u]), 64'(e.stable));
        @(posedge clk); #1;
        checkOutput({e.tag, "_done_pulse"}, 64'(done[u]), 64'd0);
        checkOutput({e.tag, "_idle_busy"}, 64'(busy[u]), 64'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        ena = '1; wr_en = '0; start = '0; wr_row = '0; wr_data = '0;
        birth = '0; survive = '0; steps = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int u = 0; u < NU; u++) begin
            checkOutput("reset_board", cur_board(u), 64'd0);
            checkOutput("reset_gen", 64'(gen[u]), 64'd0);
            checkOutput("reset_busy", 64'(busy[u]), 64'd0);
            checkOutput("reset_done", 64'(done[u]), 64'd0);
            checkOutput("reset_stable", 64'(stable[u]), 64'd0);
            checkOutput("reset_extinct", 64'(extinct[u]), 64'd1);
        end

        load_board(0, 64'h0000_0000_1C00_0000);
        applyStimulus(0, 1, CONWAY_B, CONWAY_S, 0, 0, 1'b0, "blinker1");
        checkOutput("blinker_vertical", cur_board(0), 64'h0000_0008_0808_0000);
        checkOutput("blinker_extinct", 64'(extinct[0]), 64'd0);
        applyStimulus(0, 1, CONWAY_B, CONWAY_S, 0, 0, 1'b0, "blinker2");
        checkOutput("blinker_restored", cur_board(0), 64'h0000_0000_1C00_0000);
        checkOutput("blinker_gen2", 64'(gen[0]), 64'd2);

        do_reset();
        load_board(0, 64'h0000_0000_0006_0600);
        applyStimulus(0, 10, CONWAY_B, CONWAY_S, 0, 0, 1'b0, "block");
        checkOutput("block_unchanged", cur_board(0), 64'h0000_0000_0006_0600);
        checkOutput("block_stable", 64'(stable[0]), 64'd1);
        checkOutput("block_gen", 64'(gen[0]), 64'd0);

        load_board(0, 64'd0);
        applyStimulus(0, 5, CONWAY_B, CONWAY_S, 0, 0, 1'b0, "empty");
        checkOutput("empty_extinct", 64'(extinct[0]), 64'd1);

        load_board(0, GLIDER);
        applyStimulus(0, 32, CONWAY_B, CONWAY_S, 0, 0, 1'b0, "glider_wrap");
        checkOutput("glider_wrap_home", cur_board(0), GLIDER);
        checkOutput("glider_wrap_gen", 64'(gen[0]), 64'd32);

        load_board(1, GLIDER);
        applyStimulus(1, 32, CONWAY_B, CONWAY_S, 0, 0, 1'b0, "glider_dead");
        checkOutput("glider_dead_stable", 64'(stable[1]), 64'd1);

        load_board(0, GLIDER);
        applyStimulus(0, 3, CONWAY_B, CONWAY_S, 2, 5, 1'b0, "stall");

        applyStimulus(0, 0, CONWAY_B, CONWAY_S, 0, 0, 1'b0, "zero_steps");

        load_board(0, GLIDER);
        applyStimulus(0, 3, CONWAY_B, CONWAY_S, 0, 0, 1'b1, "wr_in_run");

        load_board(2, GLIDER);
        @(negedge clk);
        wr_en[2] = 1'b1; wr_row[2] = 3'd6; wr_data[2] = 8'hFF;
        @(negedge clk);
        wr_row[2] = 3'd7;
        @(negedge clk);
        wr_en[2] = 1'b0;
        checkOutput("row_out_of_range", cur_board(2), mboard[2]);
        applyStimulus(2, 4, CONWAY_B, CONWAY_S, 0, 0, 1'b0, "glider_h6");

        load_board(0, 64'h0000_0E12_2224_3800);
        applyStimulus(0, 6, HIGHL_B, CONWAY_S, 0, 0, 1'b0, "highlife");

        load_board(0, GLIDER);
        @(negedge clk);
        birth[0] = CONWAY_B; survive[0] = CONWAY_S; steps[0] = 16'd10; start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        checkOutput("abort_board", cur_board(0), mboard[0]);
        checkOutput("abort_extinct", 64'(extinct[0]), 64'd1);
        checkOutput("abort_busy", 64'(busy[0]), 64'd0);
        checkOutput("abort_gen", 64'(gen[0]), 64'(mgen[0]));
        checkOutput("abort_done", 64'(done[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            checkOutput("abort_no_done", 64'(done[0]), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
